stopwatch_display_scan: RTL and testbench
=========================================

// Module: stopwatch_display_scan
// PURPOSE
//   Consumer end of the stopwatch time bus: takes the 16-bit BCD MM:SS word the stopwatch drives
//   and time-multiplexes it onto a 4-digit common-anode 7-segment display. A frame-coherent
//   snapshot plus a per-digit scan FSM with anode guard time give a tear-free, ghost-free readout.
//   Flags any non-BCD nibble. Sits between the stopwatch Q bus and the board display pins.
// PARAMETERS
//   SCAN_DIV  50000  clk_in cycles per digit slot (>= GUARD+2)
//   GUARD     4      cycles at the start of each slot with all anodes off (anti-ghosting)
//   DP_DIGIT  2      digit index whose decimal point is lit as the MM:SS separator (0..3)
// PORTS
//   clk_in      in   1   system clock; all logic on rising edge
//   RESET_N     in   1   asynchronous, active-low reset
//   TIME_BCD    in   16  [4:1] sec units, [8:5] sec tens, [12:9] min units, [16:13] min tens
//   BLANK       in   1   1 = force display dark (scan keeps running)
//   SEG         out  7   segments active-low; SEG[1]=a .. SEG[7]=g
//   DP          out  1   decimal point, active-low
//   AN          out  4   anodes active-low; AN[1] = digit 0 (sec units) .. AN[4] = digit 3
//   FRAME_DONE  out  1   one-cycle pulse at end of digit-3 slot
//   DIGIT_ERR   out  1   high for a frame whose snapshot holds any nibble > 9
// BEHAVIOUR
//   - Reset (async assert, sync-released by flops): tick=0, idx=0, snapshot=16'h0000, AN=4'b1111,
//     SEG=7'h7F, DP=1, FRAME_DONE=0, DIGIT_ERR=0.
//   - tick counts 0..SCAN_DIV-1, wraps to 0; on wrap idx advances 0->1->2->3->0.
//   - FSM per slot: GUARD (tick < GUARD: AN=4'b1111) -> SHOW (AN = one-hot-low of idx).
//   - Snapshot: TIME_BCD captured on the cycle idx wraps 3->0 and on the first cycle after
//     reset release; all four digits of a frame come from one snapshot (TIME_BCD changes
//     mid-frame are not visible until the next frame).
//   - DIGIT_ERR updated at each snapshot capture: OR of (nibble > 9) over the 4 captured nibbles.
//   - Decode (active-low, {g,f,e,d,c,b,a}): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//     5=0010010 6=0000010 7=1111000 8=0000000 9=0010000; nibble 10..15 -> dash 0111111.
//   - DP=0 only while SHOW and idx==DP_DIGIT; else 1.
//   - All outputs registered: SEG/DP/AN reflect tick/idx state with 1-cycle latency.
//   - FRAME_DONE=1 for exactly the one cycle after the cycle where idx==3 and tick==SCAN_DIV-1.
//   - BLANK=1: AN=4'b1111, DP=1 next cycle; tick/idx/snapshot/FRAME_DONE unaffected.
//   - BLANK and snapshot in same cycle: snapshot still captured.
//   - RESET_N asserted mid-slot: outputs go to reset values immediately (asynchronously).
// CONFIGURATION
//   DISP_LEADING_ZERO_BLANK_EN defined: digit 3 (min tens) with captured nibble 0 keeps AN[4]=1
//     for its whole SHOW phase (display reads " 9:59"); nonzero or invalid nibble shown normally.
//   Not defined: digit 3 always shown, 0 decoded as 1000000.
// TESTING (SCAN_DIV=8, GUARD=2, DP_DIGIT=2)
//   1 Reset release, TIME_BCD=16'h1234 -> AN 1111 for cycles 0-2, then AN=1110 SEG=0011001 ("4");
//     slots follow 3,2,1; DP=0 only during digit-2 SHOW; FRAME_DONE pulse after 32 cycles.
//   2 Change TIME_BCD 16'h1234->16'h4930 during digit-1 slot -> digits 2,3 still show 2,1;
//     next frame shows 0,3,9,4.
//   3 TIME_BCD=16'h12A4 -> digit-1 slot SEG=0111111; DIGIT_ERR=1 for that frame; cleared at
//     next snapshot after TIME_BCD=16'h1234.
//   4 BLANK=1 for 20 cycles mid-frame -> AN=1111, DP=1 throughout; FRAME_DONE timing unchanged.
//   5 RESET_N low during digit-2 SHOW -> AN=1111, SEG=7'h7F same cycle; restart at idx 0.
//   6 TIME_BCD=16'h0959: macro defined -> AN[4] never low; undefined -> digit 3 SEG=1000000.

Source files
------------

// File: rtl/stopwatch_display_scan.sv
// Scans a 16-bit BCD MM:SS word onto a 4-digit common-anode 7-segment display. Each frame of
// four digits comes from a single snapshot. Optional macro: DISP_LEADING_ZERO_BLANK_EN.
module stopwatch_display_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 4,
  parameter int DP_DIGIT = 2
) (
  input  logic        clk_in,
  input  logic        RESET_N,
  input  logic [16:1] TIME_BCD,
  input  logic        BLANK,
  output logic [7:1]  SEG,
  output logic        DP,
  output logic [4:1]  AN,
  output logic        FRAME_DONE,
  output logic        DIGIT_ERR
);

  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
  localparam logic [TW-1:0] GUARD_T   = TW'(GUARD);
  localparam logic [1:0]    DP_IDX    = 2'(DP_DIGIT);

  typedef enum logic {PH_GUARD, PH_SHOW} phase_e;
  localparam phase_e PH_RESET = (GUARD > 0) ? PH_GUARD : PH_SHOW;

  // Active-low segments, bit order {g,f,e,d,c,b,a}; non-BCD nibbles show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  function automatic logic has_bad_nibble(input logic [16:1] w);
    has_bad_nibble = (w[4:1] > 4'd9) || (w[8:5] > 4'd9) ||
                     (w[12:9] > 4'd9) || (w[16:13] > 4'd9);
  endfunction

  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    idx_q, idx_d;
  phase_e        phase_q, phase_d;
  logic          first_q;
  logic [16:1]   snap_q, snap_d, snap_view;
  logic          err_q, err_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          fd_q, fd_d;

  logic       tick_wrap, frame_last, capture, lit, lz_blank;
  logic [3:0] nib;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    tick_wrap  = (tick_q == TICK_LAST);
    frame_last = tick_wrap && (idx_q == 2'd3);
    tick_d     = tick_wrap ? '0 : tick_q + TW'(1);
    idx_d      = tick_wrap ? idx_q + 2'd1 : idx_q;
    phase_d    = (tick_d < GUARD_T) ? PH_GUARD : PH_SHOW;

    // The first cycle after reset displays the word being captured, not the cleared snapshot.
    capture   = first_q || frame_last;
    snap_d    = capture ? TIME_BCD : snap_q;
    err_d     = capture ? has_bad_nibble(TIME_BCD) : err_q;
    snap_view = first_q ? TIME_BCD : snap_q;

    nib = 4'd0;
    case (idx_q)
      2'd0:    nib = snap_view[4:1];
      2'd1:    nib = snap_view[8:5];
      2'd2:    nib = snap_view[12:9];
      default: nib = snap_view[16:13];
    endcase

`ifdef DISP_LEADING_ZERO_BLANK_EN
    lz_blank = (idx_q == 2'd3) && (nib == 4'd0);
`else
    lz_blank = 1'b0;
`endif

    lit   = (phase_q == PH_SHOW) && !BLANK;
    an_d  = (lit && !lz_blank) ? ~(4'b0001 << idx_q) : 4'b1111;
    dp_d  = !(lit && (idx_q == DP_IDX));
    seg_d = seg_decode(nib);
    fd_d  = frame_last;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge RESET_N) begin
    if (!RESET_N) begin
      tick_q  <= '0;
      idx_q   <= 2'd0;
      phase_q <= PH_RESET;
      first_q <= 1'b1;
      snap_q  <= 16'h0000;
      err_q   <= 1'b0;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      an_q    <= 4'b1111;
      fd_q    <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      first_q <= 1'b0;
      snap_q  <= snap_d;
      err_q   <= err_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      fd_q    <= fd_d;
    end
  end

  assign SEG        = seg_q;
  assign DP         = dp_q;
  assign AN         = an_q;
  assign FRAME_DONE = fd_q;
  assign DIGIT_ERR  = err_q;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Scoreboard bench for stopwatch_display_scan: the stimulus side predicts each post-edge output
// from frame/slot arithmetic, and a monitor pops and compares one entry per clock edge.
module tb_stopwatch_display_scan;

  localparam int SCAN_DIV = 8;
  localparam int GUARD    = 2;
  localparam int DP_DIGIT = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic        clk_in = 1'b0;
  logic        RESET_N;
  logic [16:1] TIME_BCD;
  logic        BLANK;
  logic [7:1]  SEG;
  logic        DP;
  logic [4:1]  AN;
  logic        FRAME_DONE;
  logic        DIGIT_ERR;

  stopwatch_display_scan #(.SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .DP_DIGIT(DP_DIGIT)) dut (
    .clk_in    (clk_in),
    .RESET_N   (RESET_N),
    .TIME_BCD  (TIME_BCD),
    .BLANK     (BLANK),
    .SEG       (SEG),
    .DP        (DP),
    .AN        (AN),
    .FRAME_DONE(FRAME_DONE),
    .DIGIT_ERR (DIGIT_ERR)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int         edge_n;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       fd;
    logic       err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_x;
  int          total = 0;
  int          bad   = 0;
  int          e;
  logic [15:0] snap_frame[int];
  logic        err_cur;
  logic [6:0]  seg_tab[16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                               7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

  task automatic check(input string name, input int en, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", name, en, act, req);
    end
  endtask

  function automatic logic bad_bcd(input logic [15:0] w);
    for (int i = 0; i < 4; i++)
      if (((w >> (4 * i)) & 16'hF) > 16'd9) return 1'b1;
    return 1'b0;
  endfunction

  // Edge e after reset release shows the state reached after e-1 edges: slot = (e-1)/SCAN_DIV.
  // Frame 0 uses the word present at edge 1, frame F>0 the word present at edge F*FRAME.
  task automatic drive(input logic [15:0] t, input logic b);
    exp_t       x;
    int         s, tick, idx, f;
    logic [3:0] nib;
    logic       lit;
    @(negedge clk_in);
    TIME_BCD = t;
    BLANK    = b;
    e++;
    s    = e - 1;
    tick = s % SCAN_DIV;
    idx  = (s / SCAN_DIV) % 4;
    f    = s / FRAME;
    if (e == 1 || e % FRAME == 0) begin
      snap_frame[(e == 1) ? 0 : e / FRAME] = t;
      err_cur = bad_bcd(t);
    end
    nib = 4'((snap_frame[f] >> (4 * idx)) & 16'hF);
    lit = (tick >= GUARD) && !b;
    x.edge_n = e;
    x.seg    = seg_tab[nib];
    x.an     = lit ? (4'hF ^ 4'(1 << idx)) : 4'hF;
`ifdef DISP_LEADING_ZERO_BLANK_EN
    if (idx == 3 && nib == 4'd0) x.an = 4'hF;
`endif
    x.dp  = !(lit && idx == DP_DIGIT);
    x.fd  = (s % FRAME == FRAME - 1);
    x.err = err_cur;
    exp_q.push_back(x);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_an"},  e, 32'(AN),         32'hF);
    check({tag, "_seg"}, e, 32'(SEG),        32'h7F);
    check({tag, "_dp"},  e, 32'(DP),         32'h1);
    check({tag, "_fd"},  e, 32'(FRAME_DONE), 32'h0);
    check({tag, "_err"}, e, 32'(DIGIT_ERR),  32'h0);
  endtask

  task automatic release_reset();
    @(posedge clk_in);
    #2 RESET_N = 1'b1;
    e = 0;
    err_cur = 1'b0;
    snap_frame.delete();
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    w = '0;
    for (int i = 0; i < 4; i++) w |= 16'($urandom_range(0, 9)) << (4 * i);
    return w;
  endfunction

  initial begin : monitor
    forever begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() != 0) begin
        mon_x = exp_q.pop_front();
        check("seg", mon_x.edge_n, 32'(SEG),        32'(mon_x.seg));
        check("an",  mon_x.edge_n, 32'(AN),         32'(mon_x.an));
        check("dp",  mon_x.edge_n, 32'(DP),         32'(mon_x.dp));
        check("fd",  mon_x.edge_n, 32'(FRAME_DONE), 32'(mon_x.fd));
        check("err", mon_x.edge_n, 32'(DIGIT_ERR),  32'(mon_x.err));
      end
    end
  end

  initial begin : stimulus
    logic [15:0] w;
    RESET_N  = 1'b0;
    TIME_BCD = 16'h1234;
    BLANK    = 1'b0;
    e        = 0;
    err_cur  = 1'b0;
    #12;
    check_reset_state("rst");
    release_reset();

    // Word changes during the digit-1 slot; frame 0 keeps 1234, frame 1 shows 4930.
    for (int i = 1; i <= 12; i++) drive(16'h1234, 1'b0);
    for (int i = 13; i <= 63; i++) drive(16'h4930, 1'b0);
    // Frame with a non-BCD nibble, then a clean frame clearing the error flag.
    for (int i = 64; i <= 95; i++) drive(16'h12A4, 1'b0);
    for (int i = 96; i <= 127; i++) drive(16'h1234, (i >= 100 && i < 120));
    // Random words and blanking over five frames.
    w = rand_word();
    for (int i = 128; i <= 287; i++) begin
      if ($urandom_range(0, 7) == 0) w = rand_word();
      drive(w, ($urandom_range(0, 5) == 0));
    end
    for (int i = 288; i <= 319; i++) drive(16'h0959, 1'b0);
    // Invalid word so the error flag is set when reset hits during the digit-2 SHOW phase.
    for (int i = 320; i <= 340; i++) drive(16'h9A59, 1'b0);
    @(negedge clk_in);
    check("pre_rst_an", e, 32'(AN), 32'hB);
    RESET_N = 1'b0;
    #1;
    check_reset_state("async_rst");
    repeat (3) @(posedge clk_in);
    release_reset();
    for (int i = 1; i <= 40; i++) drive(16'h5817, 1'b0);

    @(posedge clk_in);
    #3;
    check("queue_drained", e, 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
